reg_writeback: RTL and testbench

- Write-side owner of the register file's single write port (we, rd_index, rd_write).
- Merges two result sources:
  - the in-order pipeline result, which is always accepted;
  - the long-latency unit (mul/div) result, which uses a valid/ready handshake and a 2-entry buffer.
- Holds a pending-write scoreboard so the issue stage can stall readers of registers whose long-latency result is outstanding.

---
 rtl/reg_writeback.sv | 136 +++++++++++++
 tb/tb_reg_writeback.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Register-file write-port owner: merges in-order pipeline results with buffered
// long-latency results and tracks outstanding long-latency destinations.
module reg_writeback #(
  parameter int LU_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  input  logic [4:0]  rj_index,
  input  logic [4:0]  rk_index,
  input  logic [4:0]  rq_index,
  output logic        rj_busy,
  output logic        rk_busy,
  output logic        rq_busy,
  output logic        we,
  output logic [4:0]  rd_index,
  output logic [31:0] rd_write
);

  localparam int PW = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int CW = $clog2(LU_DEPTH + 1);

  logic [4:0]    fifo_rd_q   [LU_DEPTH];
  logic [31:0]   fifo_data_q [LU_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic          we_q, we_d;
  logic [4:0]    rd_index_q, rd_index_d;
  logic [31:0]   rd_write_q, rd_write_d;
  logic          lu_src_q, lu_src_d;

  logic [31:1]   busy_q, busy_d;
  logic [31:0]   busy_vec;

  logic          push, pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  // Ready depends only on the registered count, never on lu_valid.
  assign lu_ready  = (count_q != CW'(LU_DEPTH));
  assign push      = lu_valid && lu_ready;
  assign pop       = !pipe_valid && (count_q != '0);
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= lu_rd;
      fifo_data_q[wr_ptr_q] <= lu_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pipeline wins outright; a pipeline write to r0 still blocks the pop.
  always_comb begin
    we_d       = 1'b0;
    rd_index_d = rd_index_q;
    rd_write_d = rd_write_q;
    lu_src_d   = lu_src_q;
    if (pipe_valid) begin
      if (pipe_rd != 5'd0) begin
        we_d       = 1'b1;
        rd_index_d = pipe_rd;
        rd_write_d = pipe_data;
        lu_src_d   = 1'b0;
      end
    end else if (pop) begin
      we_d       = (head_rd != 5'd0);
      rd_index_d = head_rd;
      rd_write_d = head_data;
      lu_src_d   = 1'b1;
    end
  end

  // Busy bits clear on the edge the register file captures the data; set wins.
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      always_comb begin
        busy_d[gi] = busy_q[gi];
        if (lu_issue && (lu_issue_rd == 5'(gi)))
          busy_d[gi] = 1'b1;
        else if (we_q && lu_src_q && (rd_index_q == 5'(gi)))
          busy_d[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      rd_index_q <= 5'd0;
      rd_write_q <= 32'd0;
      lu_src_q   <= 1'b0;
      busy_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      we_q       <= we_d;
      rd_index_q <= rd_index_d;
      rd_write_q <= rd_write_d;
      lu_src_q   <= lu_src_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_vec = {busy_q, 1'b0};
  assign rj_busy  = busy_vec[rj_index];
  assign rk_busy  = busy_vec[rk_index];
  assign rq_busy  = busy_vec[rq_index];

  assign we       = we_q;
  assign rd_index = rd_index_q;
  assign rd_write = rd_write_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writebacks are queued when stimulus
// is driven and matched against each observed register-file write.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic [4:0]  rj_index, rk_index, rq_index;
  logic        rj_busy, rk_busy, rq_busy;
  logic        we;
  logic [4:0]  rd_index;
  logic [31:0] rd_write;

  int total  = 0;
  int passed = 0;
  logic [36:0] pipe_q[$];
  logic [36:0] lu_q[$];

  always #5 clk = ~clk;

  reg_writeback #(.LU_DEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rj_index(rj_index), .rk_index(rk_index), .rq_index(rq_index),
    .rj_busy(rj_busy), .rk_busy(rk_busy), .rq_busy(rq_busy),
    .we(we), .rd_index(rd_index), .rd_write(rd_write)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = v;
    pipe_rd    = rd;
    pipe_data  = d;
    if (v && rd != 5'd0) pipe_q.push_back({rd, d});
  endtask

  // One clock; any write seen afterwards is matched against the proper queue.
  task automatic tick();
    logic        exp_pipe;
    logic [36:0] e;
    exp_pipe = pipe_valid && (pipe_rd != 5'd0) && rstn;
    @(posedge clk);
    #1;
    if (exp_pipe) begin
      chk("pipe_we", 64'(we), 64'(1));
      if (pipe_q.size() > 0) begin
        e = pipe_q.pop_front();
        chk("pipe_wb", 64'({rd_index, rd_write}), 64'(e));
      end
      $display("wb pipe rd=%0d data=%h", rd_index, rd_write);
    end else if (we === 1'b1) begin
      if (lu_q.size() == 0) begin
        chk("unexpected_we", 64'(we), 64'(0));
      end else begin
        e = lu_q.pop_front();
        chk("lu_wb", 64'({rd_index, rd_write}), 64'(e));
      end
      $display("wb lu   rd=%0d data=%h", rd_index, rd_write);
    end
  endtask

  initial begin
    rstn = 1'b0;
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_issue = 1'b0; lu_issue_rd = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    rj_index = '0; rk_index = '0; rq_index = '0;
    #12;
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_rd_index", 64'(rd_index), 64'(0));
    chk("rst_rd_write", 64'(rd_write), 64'(0));
    chk("rst_lu_ready", 64'(lu_ready), 64'(1));
    rstn = 1'b1;

    // Single pipeline write, then idle.
    drive_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    drive_pipe(1'b0, 5'd0, 32'h0);
    tick();
    chk("pipe_idle_we", 64'(we), 64'(0));

    // Pipeline write to r0 is dropped and leaves the FIFO alone.
    drive_pipe(1'b1, 5'd0, 32'h1234);
    tick();
    chk("r0_we", 64'(we), 64'(0));
    chk("r0_lu_ready", 64'(lu_ready), 64'(1));
    drive_pipe(1'b0, 5'd0, 32'h0);

    // Issue rd=7, then deliver its result with the pipe idle.
    lu_issue = 1'b1; lu_issue_rd = 5'd7; rj_index = 5'd7;
    #1 chk("busy7_before", 64'(rj_busy), 64'(0));
    tick();
    lu_issue = 1'b0;
    #1 chk("busy7_set", 64'(rj_busy), 64'(1));
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h42;
    lu_q.push_back({5'd7, 32'h42});
    tick();
    lu_valid = 1'b0;
    chk("lu_we_1cyc", 64'(we), 64'(0));
    tick();
    chk("lu_we_2cyc", 64'(we), 64'(1));
    chk("busy7_during_wb", 64'(rj_busy), 64'(1));
    tick();
    chk("busy7_cleared", 64'(rj_busy), 64'(0));
    chk("lu_we_done", 64'(we), 64'(0));

    // Pipe held busy for 4 cycles while the FIFO fills.
    drive_pipe(1'b1, 5'd20, 32'd100);
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'hA;
    chk("fill_ready0", 64'(lu_ready), 64'(1));
    lu_q.push_back({5'd3, 32'hA});
    tick();
    drive_pipe(1'b1, 5'd21, 32'd101);
    lu_rd = 5'd4; lu_data = 32'hB;
    chk("fill_ready1", 64'(lu_ready), 64'(1));
    lu_q.push_back({5'd4, 32'hB});
    tick();
    drive_pipe(1'b1, 5'd22, 32'd102);
    lu_rd = 5'd5; lu_data = 32'hC;
    chk("full_ready_a", 64'(lu_ready), 64'(0));
    tick();
    drive_pipe(1'b1, 5'd23, 32'd103);
    chk("full_ready_b", 64'(lu_ready), 64'(0));
    tick();
    drive_pipe(1'b0, 5'd0, 32'h0);
    chk("full_ready_c", 64'(lu_ready), 64'(0));
    tick();
    chk("ready_after_pop", 64'(lu_ready), 64'(1));
    lu_q.push_back({5'd5, 32'hC});
    tick();
    chk("ready_pushpop", 64'(lu_ready), 64'(1));
    lu_valid = 1'b0;
    tick();
    tick();
    chk("drain_we", 64'(we), 64'(0));
    chk("drain_ready", 64'(lu_ready), 64'(1));

    // Re-issue of rd=9 on the edge its writeback clears it: set wins.
    lu_issue = 1'b1; lu_issue_rd = 5'd9;
    tick();
    lu_issue = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    lu_q.push_back({5'd9, 32'h99});
    tick();
    lu_valid = 1'b0;
    tick();
    lu_issue = 1'b1; lu_issue_rd = 5'd9; rj_index = 5'd9; rq_index = 5'd9;
    #1 chk("busy9_during_wb", 64'(rj_busy), 64'(1));
    tick();
    lu_issue = 1'b0;
    #1 chk("busy9_set_wins", 64'(rj_busy), 64'(1));
    chk("busy9_rq", 64'(rq_busy), 64'(1));

    // Fill FIFO with busy[3] set, then pulse asynchronous reset.
    lu_issue = 1'b1; lu_issue_rd = 5'd3;
    tick();
    lu_issue = 1'b0;
    drive_pipe(1'b1, 5'd25, 32'd55);
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h33;
    tick();
    drive_pipe(1'b1, 5'd26, 32'd56);
    lu_rd = 5'd4; lu_data = 32'h44;
    tick();
    lu_valid = 1'b0;
    drive_pipe(1'b0, 5'd0, 32'h0);
    rk_index = 5'd3; rj_index = 5'd3;
    #1;
    chk("pre_rst_full", 64'(lu_ready), 64'(0));
    chk("pre_rst_busy3", 64'(rk_busy), 64'(1));
    chk("pre_rst_we", 64'(we), 64'(1));
    rstn = 1'b0;
    #1;
    chk("arst_we", 64'(we), 64'(0));
    chk("arst_rd_index", 64'(rd_index), 64'(0));
    chk("arst_rd_write", 64'(rd_write), 64'(0));
    chk("arst_ready", 64'(lu_ready), 64'(1));
    chk("arst_busy3", 64'(rk_busy), 64'(0));
    #4 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale_we", 64'(we), 64'(0));
    end
    chk("post_rst_ready", 64'(lu_ready), 64'(1));

    chk("lu_q_empty", 64'(lu_q.size()), 64'(0));
    chk("pipe_q_empty", 64'(pipe_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
